// File: rtl/child_seq_pkg.sv
// child_seq_pkg: shared types and helpers for the child instance sequencer.
//   seq_state_e     - sequencer FSM state encoding
//   MaxChild        - widest child bank the helpers support
//   next_unskipped  - lowest set bit at or above a position in a run mask, -1 if none
package child_seq_pkg;

   localparam int unsigned MaxChild = 32;

   typedef enum logic [1:0] {
      StIdle,
      StLaunch,
      StWait,
      StDone
   } seq_state_e;

   // run_mask bit k = 1 means child k is still to be serviced in this sequence.
   function automatic int next_unskipped(input logic [MaxChild-1:0] run_mask, input int from);
      int pos;
      pos = -1;
      // Scan downwards so the last hit is the lowest qualifying index.
      for (int i = MaxChild - 1; i >= 0; i--) begin
         if (run_mask[i] && (i >= from)) begin
            pos = i;
         end
      end
      return pos;
   endfunction

endpackage

// File: rtl/child_seq_wait_timer.sv
// child_seq_wait_timer: per-child wait counter for the sequencer timeout.
//   clk, rst_n  - clock, asynchronous active-low reset
//   clr_i       - synchronous clear to zero (wins over en_i)
//   en_i        - count one per cycle while high; saturates at all-ones
//   expired_o   - high while enabled and the count has reached LIMIT
module child_seq_wait_timer
   import child_seq_pkg::*;
#(
   parameter int unsigned CNT_W = 8,
   parameter int unsigned LIMIT = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = en_i && (cnt_q >= CNT_W'(LIMIT));

endmodule

// File: rtl/child_inst_sequencer.sv
// child_inst_sequencer: services a bank of NUM_CHILD children one at a time
// (start pulse, wait for done, record status, advance to next unskipped child).
//   clk, rst_n      - clock, asynchronous active-low reset
//   start_i         - begin a sequence (accepted only when idle)
//   abort_i         - abandon the running sequence
//   skip_mask_i     - children to skip, captured on accepted start
//   child_start_o   - one-hot single-cycle start pulse
//   child_done_i    - per-child completion (level or pulse)
//   busy_o, done_o  - sequence in progress / one-cycle end-of-sequence pulse
//   active_idx_o    - child being serviced (holds last after the sequence)
//   pass_mask_o     - children that completed
//   timeout_mask_o  - children that timed out
//   aborted_o       - last sequence ended by abort
// Build option: define CHILD_SEQ_TIMEOUT_EN to add the per-child wait timeout;
// without it WAIT only exits on done or abort and timeout_mask_o is zero.
module child_inst_sequencer
   import child_seq_pkg::*;
#(
   parameter int unsigned NUM_CHILD      = 5,
   parameter int unsigned IDX_W          = (NUM_CHILD > 1) ? $clog2(NUM_CHILD) : 1,
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned CNT_W          = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start_i,
   input  logic                 abort_i,
   input  logic [NUM_CHILD-1:0] skip_mask_i,
   output logic [NUM_CHILD-1:0] child_start_o,
   input  logic [NUM_CHILD-1:0] child_done_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic [IDX_W-1:0]     active_idx_o,
   output logic [NUM_CHILD-1:0] pass_mask_o,
   output logic [NUM_CHILD-1:0] timeout_mask_o,
   output logic                 aborted_o
);

   seq_state_e           state_q;
   logic [NUM_CHILD-1:0] skip_q;
   logic [IDX_W-1:0]     idx_q;
   logic [NUM_CHILD-1:0] child_start_q;
   logic                 busy_q;
   logic                 done_q;
   logic [NUM_CHILD-1:0] pass_q;
   logic                 aborted_q;

   logic [MaxChild-1:0]  live_run;
   logic [MaxChild-1:0]  kept_run;
   logic                 first_ok;
   logic [IDX_W-1:0]     first_idx;
   logic                 after_ok;
   logic [IDX_W-1:0]     after_idx;
   logic                 cur_done;
   logic                 wait_exit;

   // Candidate indices: first child of a new sequence (from the live skip input)
   // and the next child after the current one (from the captured skip mask).
   always_comb begin
      live_run                  = '0;
      live_run[NUM_CHILD-1:0]   = ~skip_mask_i;
      kept_run                  = '0;
      kept_run[NUM_CHILD-1:0]   = ~skip_q;
      first_ok  = next_unskipped(live_run, 0) >= 0;
      first_idx = IDX_W'(next_unskipped(live_run, 0));
      after_ok  = next_unskipped(kept_run, int'(idx_q) + 1) >= 0;
      after_idx = IDX_W'(next_unskipped(kept_run, int'(idx_q) + 1));
   end

   assign cur_done = child_done_i[idx_q];

`ifdef CHILD_SEQ_TIMEOUT_EN
   logic                 expired;
   logic [NUM_CHILD-1:0] timeout_q;

   child_seq_wait_timer #(
      .CNT_W (CNT_W),
      .LIMIT (TIMEOUT_CYCLES)
   ) u_wait_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr_i     (state_q == StLaunch),
      .en_i      (state_q == StWait),
      .expired_o (expired)
   );

   assign wait_exit      = cur_done || expired;
   assign timeout_mask_o = timeout_q;
`else
   logic unused_cfg;
   assign unused_cfg     = ^{TIMEOUT_CYCLES[0], CNT_W[0]};
   assign wait_exit      = cur_done;
   assign timeout_mask_o = '0;
`endif

   // Outputs are registered from the current state, so they trail the state by a
   // cycle: a LAUNCH cycle produces the start pulse on the following cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= StIdle;
         skip_q        <= '0;
         idx_q         <= '0;
         child_start_q <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         pass_q        <= '0;
         aborted_q     <= 1'b0;
`ifdef CHILD_SEQ_TIMEOUT_EN
         timeout_q     <= '0;
`endif
      end else begin
         child_start_q <= '0;
         done_q        <= 1'b0;
         unique case (state_q)
            StIdle: begin
               // busy stays up through the done_o cycle, then drops unless restarted.
               busy_q <= start_i;
               if (start_i) begin
                  skip_q    <= skip_mask_i;
                  pass_q    <= '0;
                  aborted_q <= 1'b0;
`ifdef CHILD_SEQ_TIMEOUT_EN
                  timeout_q <= '0;
`endif
                  if (first_ok) begin
                     idx_q   <= first_idx;
                     state_q <= StLaunch;
                  end else begin
                     idx_q   <= '0;
                     state_q <= StDone;
                  end
               end
            end
            StLaunch: begin
               if (abort_i) begin
                  aborted_q <= 1'b1;
                  state_q   <= StDone;
               end else begin
                  child_start_q <= NUM_CHILD'(1) << idx_q;
                  state_q       <= StWait;
               end
            end
            StWait: begin
               // Abort beats a same-cycle done or expiry; done beats expiry.
               if (abort_i) begin
                  aborted_q <= 1'b1;
                  state_q   <= StDone;
               end else if (wait_exit) begin
                  if (cur_done) pass_q[idx_q] <= 1'b1;
`ifdef CHILD_SEQ_TIMEOUT_EN
                  else timeout_q[idx_q] <= 1'b1;
`endif
                  if (after_ok) begin
                     idx_q   <= after_idx;
                     state_q <= StLaunch;
                  end else begin
                     state_q <= StDone;
                  end
               end
            end
            StDone: begin
               done_q  <= 1'b1;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign child_start_o = child_start_q;
   assign busy_o        = busy_q;
   assign done_o        = done_q;
   assign active_idx_o  = idx_q;
   assign pass_mask_o   = pass_q;
   assign aborted_o     = aborted_q;

endmodule

// File: tb/tb_child_inst_sequencer.sv
// tb_child_inst_sequencer: randomized bench with a timeline model of the sequencer.
// Cycle 0 of a run is the cycle start_i is presented; all expectations are
// indexed by cycle relative to that.
module tb_child_inst_sequencer;

   localparam int NC   = 5;
   localparam int TO   = 4;
   localparam int MAXC = 1200;
`ifdef CHILD_SEQ_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start_i;
   logic          abort_i;
   logic [NC-1:0] skip_mask_i;
   logic [NC-1:0] child_start_o;
   logic [NC-1:0] child_done_i;
   logic          busy_o;
   logic          done_o;
   logic [2:0]    active_idx_o;
   logic [NC-1:0] pass_mask_o;
   logic [NC-1:0] timeout_mask_o;
   logic          aborted_o;

   always #5 clk = ~clk;

   child_inst_sequencer #(
      .NUM_CHILD      (NC),
      .TIMEOUT_CYCLES (TO),
      .CNT_W          (8)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start_i        (start_i),
      .abort_i        (abort_i),
      .skip_mask_i    (skip_mask_i),
      .child_start_o  (child_start_o),
      .child_done_i   (child_done_i),
      .busy_o         (busy_o),
      .done_o         (done_o),
      .active_idx_o   (active_idx_o),
      .pass_mask_o    (pass_mask_o),
      .timeout_mask_o (timeout_mask_o),
      .aborted_o      (aborted_o)
   );

   int errors = 0;
   int checks = 0;

   // Expected timeline for one run.
   logic [NC-1:0] e_start [MAXC];
   logic [NC-1:0] e_pass  [MAXC];
   logic [NC-1:0] e_to    [MAXC];
   bit            e_done  [MAXC];
   bit            e_busy  [MAXC];
   bit            e_ab    [MAXC];
   int            e_idx   [MAXC];
   int            win_lo  [NC];
   int            win_hi  [NC];
   int            done_at [NC];

   // Status carried from the previous run (visible at cycle 0 of the next).
   logic [NC-1:0] prev_pass = '0;
   logic [NC-1:0] prev_to   = '0;
   bit            prev_ab   = 1'b0;
   int            prev_idx  = 0;

   // Observations of the last run.
   logic [NC-1:0] obs_starts [$];
   int            obs_start_cyc [$];
   int            obs_done;
   int            done_cyc;

   task automatic chk(input string nm, input int c, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, c, act, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_start"}, -1, 32'(child_start_o), 32'd0);
      chk({tag, "_busy"}, -1, 32'(busy_o), 32'd0);
      chk({tag, "_done"}, -1, 32'(done_o), 32'd0);
      chk({tag, "_idx"}, -1, 32'(active_idx_o), 32'd0);
      chk({tag, "_pass"}, -1, 32'(pass_mask_o), 32'd0);
      chk({tag, "_tmo"}, -1, 32'(timeout_mask_o), 32'd0);
      chk({tag, "_abort"}, -1, 32'(aborted_o), 32'd0);
   endtask

   // Build the expected timeline from the sequencing rules, then drive and check.
   task automatic run_seq(input logic [NC-1:0] skip, input int dly [NC], input int abort_at,
                          input int rst_at);
      int t, r, e, n, first, nxt;
      bit ab, stop, tmo;
      logic [NC-1:0] d;

      first = -1;
      for (int k = NC - 1; k >= 0; k--) if (!skip[k]) first = k;
      for (int c = 0; c < MAXC; c++) begin
         e_start[c] = '0;
         e_done[c]  = 1'b0;
         e_busy[c]  = 1'b0;
         e_pass[c]  = (c == 0) ? prev_pass : '0;
         e_to[c]    = (c == 0) ? prev_to : '0;
         e_ab[c]    = (c == 0) ? prev_ab : 1'b0;
         e_idx[c]   = (c == 0) ? prev_idx : ((first < 0) ? 0 : first);
      end
      for (int k = 0; k < NC; k++) begin
         win_lo[k]  = MAXC;
         win_hi[k]  = -1;
         done_at[k] = -1;
      end

      // Child k launches (LAUNCH) at cycle t, its pulse shows at t+1, and it
      // resolves at cycle r = t+1+delay (or t+1+TO on timeout).
      t  = 1;
      e  = 1;
      ab = 1'b0;
      for (int k = 0; k < NC; k++) begin
         if (skip[k] || ab) continue;
         tmo        = TO_EN && (dly[k] > TO);
         r          = t + 1 + (tmo ? TO : dly[k]);
         win_lo[k]  = t;
         win_hi[k]  = r;
         done_at[k] = tmo ? -1 : r;
         if (abort_at >= t && abort_at <= r) begin
            if (abort_at > t) e_start[t + 1] = NC'(1) << k;
            if (done_at[k] > abort_at) done_at[k] = -1;
            for (int c = abort_at + 1; c < MAXC; c++) e_ab[c] = 1'b1;
            e  = abort_at + 1;
            ab = 1'b1;
         end else begin
            e_start[t + 1] = NC'(1) << k;
            for (int c = r + 1; c < MAXC; c++) begin
               if (tmo) e_to[c][k] = 1'b1;
               else     e_pass[c][k] = 1'b1;
            end
            nxt = -1;
            for (int j = NC - 1; j > k; j--) if (!skip[j]) nxt = j;
            if (nxt >= 0) for (int c = r + 1; c < MAXC; c++) e_idx[c] = nxt;
            t = r + 1;
            e = r + 1;
         end
      end
      e_done[e + 1] = 1'b1;
      for (int c = 1; c <= e + 1; c++) e_busy[c] = 1'b1;
      n = e + 4;

      obs_starts.delete();
      obs_start_cyc.delete();
      obs_done = 0;
      done_cyc = -1;
      stop     = 1'b0;

      for (int c = 0; c < n && !stop; c++) begin
         @(posedge clk);
         #1;
         // Extra start_i while busy must be ignored.
         start_i     = (c == 0) || (c <= e && $urandom_range(0, 3) == 0);
         skip_mask_i = (c == 0) ? skip : NC'($urandom);
         abort_i     = (c == abort_at);
         for (int k = 0; k < NC; k++) begin
            if (c >= win_lo[k] && c <= win_hi[k]) d[k] = (c == done_at[k]);
            else d[k] = ($urandom_range(0, 2) == 0);
         end
         child_done_i = d;
         @(negedge clk);
         chk("child_start", c, 32'(child_start_o), 32'(e_start[c]));
         chk("done", c, 32'(done_o), 32'(e_done[c]));
         chk("busy", c, 32'(busy_o), 32'(e_busy[c]));
         chk("pass_mask", c, 32'(pass_mask_o), 32'(e_pass[c]));
         chk("timeout_mask", c, 32'(timeout_mask_o), 32'(e_to[c]));
         chk("aborted", c, 32'(aborted_o), 32'(e_ab[c]));
         chk("active_idx", c, 32'(active_idx_o), 32'(e_idx[c]));
         if (child_start_o != '0) begin
            obs_starts.push_back(child_start_o);
            obs_start_cyc.push_back(c);
         end
         if (done_o) begin
            obs_done++;
            done_cyc = c;
         end
         if (c == rst_at) begin
            #2 rst_n = 1'b0;
            #1 chk_zero("async_reset");
            start_i      = 1'b0;
            abort_i      = 1'b0;
            child_done_i = '0;
            repeat (2) @(posedge clk);
            @(negedge clk);
            chk_zero("held_reset");
            rst_n = 1'b1;
            stop  = 1'b1;
         end
      end
      start_i      = 1'b0;
      abort_i      = 1'b0;
      child_done_i = '0;
      if (stop) begin
         prev_pass = '0;
         prev_to   = '0;
         prev_ab   = 1'b0;
         prev_idx  = 0;
      end else begin
         prev_pass = e_pass[n - 1];
         prev_to   = e_to[n - 1];
         prev_ab   = e_ab[n - 1];
         prev_idx  = e_idx[n - 1];
      end
   endtask

   task automatic chk_starts(input string nm, input int cnt, input logic [NC-1:0] codes [NC]);
      chk({nm, "_start_count"}, -1, 32'(obs_starts.size()), 32'(cnt));
      for (int i = 0; i < cnt; i++) begin
         chk({nm, "_start_code"}, i,
             (i < obs_starts.size()) ? 32'(obs_starts[i]) : 32'd0, 32'(codes[i]));
      end
   endtask

   initial begin
      int dly [NC];
      logic [NC-1:0] codes [NC];
      logic [NC-1:0] rskip;
      int rab;

      rst_n        = 1'b0;
      start_i      = 1'b0;
      abort_i      = 1'b0;
      skip_mask_i  = '0;
      child_done_i = '0;
      repeat (3) @(negedge clk);
      chk_zero("reset");
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk_zero("post_reset");

      // Normal run: every child answers 3 cycles after its pulse.
      dly = '{3, 3, 3, 3, 3};
      run_seq(5'b00000, dly, -1, -1);
      codes = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000};
      chk_starts("normal", 5, codes);
      chk("normal_pass", -1, 32'(pass_mask_o), 32'h1f);
      chk("normal_done_count", -1, 32'(obs_done), 32'd1);
      chk("normal_done_cyc", -1, 32'(done_cyc), 32'd27);
      chk("normal_start3_cyc", -1,
          (obs_start_cyc.size() > 3) ? 32'(obs_start_cyc[3]) : 32'hffff, 32'd17);
      chk("normal_busy_after", -1, 32'(busy_o), 32'd0);

      // Skip every other child.
      run_seq(5'b10101, dly, -1, -1);
      codes = '{5'b00010, 5'b01000, 5'b0, 5'b0, 5'b0};
      chk_starts("skip", 2, codes);
      chk("skip_pass", -1, 32'(pass_mask_o), 32'h0a);
      chk("skip_done_cyc", -1, 32'(done_cyc), 32'd12);

      // Everything skipped: straight to the end-of-sequence pulse.
      run_seq(5'b11111, dly, -1, -1);
      chk("skipall_start_count", -1, 32'(obs_starts.size()), 32'd0);
      chk("skipall_done_cyc", -1, 32'(done_cyc), 32'd2);
      chk("skipall_pass", -1, 32'(pass_mask_o), 32'h00);

`ifdef CHILD_SEQ_TIMEOUT_EN
      // Child 2 never answers.
      dly = '{3, 3, 1000, 3, 3};
      run_seq(5'b00000, dly, -1, -1);
      chk("tmo_timeout", -1, 32'(timeout_mask_o), 32'h04);
      chk("tmo_pass", -1, 32'(pass_mask_o), 32'h1b);
      chk("tmo_child3_cyc", -1,
          (obs_start_cyc.size() > 3) ? 32'(obs_start_cyc[3]) : 32'hffff, 32'd18);
      dly = '{3, 3, 3, 3, 3};
`endif

      // Abort coincident with child 1's done (cycle 10).
      run_seq(5'b00000, dly, 10, -1);
      codes = '{5'b00001, 5'b00010, 5'b0, 5'b0, 5'b0};
      chk_starts("abort", 2, codes);
      chk("abort_flag", -1, 32'(aborted_o), 32'd1);
      chk("abort_pass", -1, 32'(pass_mask_o), 32'h01);
      chk("abort_done_cyc", -1, 32'(done_cyc), 32'd12);

      // Abort in the very first LAUNCH cycle: no pulse at all.
      run_seq(5'b00000, dly, 1, -1);
      chk("abort_launch_starts", -1, 32'(obs_starts.size()), 32'd0);
      chk("abort_launch_flag", -1, 32'(aborted_o), 32'd1);
      chk("abort_launch_done_cyc", -1, 32'(done_cyc), 32'd3);

      // Reset while waiting on child 1, then a clean full run.
      run_seq(5'b00000, dly, -1, 8);
      run_seq(5'b00000, dly, -1, -1);
      chk("restart_pass", -1, 32'(pass_mask_o), 32'h1f);
      chk("restart_aborted", -1, 32'(aborted_o), 32'd0);

      // Very slow child 0.
      dly = '{1000, 1, 2, 1, 2};
      run_seq(5'b00000, dly, -1, -1);
`ifdef CHILD_SEQ_TIMEOUT_EN
      chk("slow_pass", -1, 32'(pass_mask_o), 32'h1e);
      chk("slow_timeout", -1, 32'(timeout_mask_o), 32'h01);
`else
      chk("slow_pass", -1, 32'(pass_mask_o), 32'h1f);
      chk("slow_timeout", -1, 32'(timeout_mask_o), 32'h00);
`endif

      // Randomized runs.
      for (int it = 0; it < 30; it++) begin
         rskip = NC'($urandom) & NC'($urandom);
         for (int k = 0; k < NC; k++) dly[k] = int'($urandom_range(1, 7));
         rab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 40)) : -1;
         run_seq(rskip, dly, rab, -1);
         repeat ($urandom_range(0, 2)) @(posedge clk);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
